// File: rtl/sprite_sched_pkg.sv
// Shared types and constants for the sprite scanline scheduler:
// fetch FSM states, sprite geometry and the horizontal mirror helper.
package sprite_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        READ,
        DONE
    } fetch_state_t;

    localparam int SPRITE_ROWS = 16;
    localparam int SPRITE_COLS = 16;
    localparam int ROW_BITS    = 8;

    // Columns 0..7 read bits 0..7; columns 8..15 read bits 7..0 (15-c == ~c in 3 bits).
    function automatic logic [2:0] mirror_index(input logic [3:0] c);
        return c[3] ? ~c[2:0] : c[2:0];
    endfunction

endpackage

// File: rtl/sprite_line_renderer.sv
// One sprite's active line buffer and column counter; drives that sprite's
// hit bit purely from registers and the live hpos/sprite_x inputs.
module sprite_line_renderer
    import sprite_sched_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [8:0]          hpos,
    input  logic [8:0]          sprite_x,
    input  logic                sprite_en,
    input  logic                commit,
    input  logic [ROW_BITS-1:0] row,
    output logic                hit
);

    logic [ROW_BITS-1:0] active;
    logic [4:0]          cnt;
    logic [3:0]          col;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active <= '0;
            cnt    <= '0;
        end else begin
            if (commit)
                active <= row;
            // A re-hit restarts the sprite even while it is mid-draw.
            if (hpos == sprite_x && sprite_en)
                cnt <= 5'(SPRITE_COLS);
            else if (cnt != 5'd0)
                cnt <= cnt - 5'd1;
        end
    end

    assign col = 4'(5'(SPRITE_COLS) - cnt);
    assign hit = (cnt != 5'd0) & active[mirror_index(col)];

endmodule

// File: rtl/sprite_scanline_scheduler.sv
// Time-shares one sprite-row ROM across NUM_SPRITES sprites during horizontal
// blank, then commits the fetched rows to per-sprite renderers at hpos 0.
module sprite_scanline_scheduler
    import sprite_sched_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int FETCH_HPOS  = 256,
    parameter int V_TOTAL     = 262
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [8:0]               hpos,
    input  logic [8:0]               vpos,
    input  logic                     display_on,
    input  logic [9*NUM_SPRITES-1:0] sprite_x,
    input  logic [9*NUM_SPRITES-1:0] sprite_y,
    input  logic [NUM_SPRITES-1:0]   sprite_en,
    output logic [3:0]               rom_yofs,
    input  logic [ROW_BITS-1:0]      rom_bits,
    output logic [NUM_SPRITES-1:0]   hit_mask,
    output logic                     gfx,
    output logic                     busy
);

    localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

    fetch_state_t        state, state_next;
    logic [IDX_W-1:0]    idx;
    logic [ROW_BITS-1:0] staging [NUM_SPRITES];

    logic [8:0] next_line, sel_y, dy;
    logic       sel_en, in_range, last, fetch_start, commit;

    assign fetch_start = (hpos == 9'(FETCH_HPOS));
    assign commit      = (hpos == 9'd0);
    assign next_line   = (vpos == 9'(V_TOTAL - 1)) ? 9'd0 : vpos + 9'd1;
    assign sel_y       = sprite_y[9*int'(idx) +: 9];
    assign sel_en      = sprite_en[idx];
    // Modulo-512 distance clips sprites straddling the frame wrap for free.
    assign dy          = next_line - sel_y;
    assign in_range    = sel_en && (dy < 9'(SPRITE_ROWS));
    assign last        = (idx == IDX_W'(NUM_SPRITES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // NOTE: next state gets a default before the case so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (fetch_start) state_next = SETUP;
            SETUP:   if (in_range) state_next = READ;
                     else if (last) state_next = DONE;
            READ:    state_next = last ? DONE : SETUP;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: staging is a small register array, not RAM, so it is cleared on reset
    // to guarantee the line after a reset renders blank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx      <= '0;
            busy     <= 1'b0;
            rom_yofs <= '0;
            for (int i = 0; i < NUM_SPRITES; i++)
                staging[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_start) begin
                        idx  <= '0;
                        busy <= 1'b1;
                    end
                end
                SETUP: begin
                    // First displayed line reads row 15, so the sprite is stored bottom-up.
                    if (in_range) begin
                        rom_yofs <= 4'd15 - dy[3:0];
                    end else begin
                        staging[idx] <= '0;
                        if (!last) idx <= idx + 1'b1;
                    end
                end
                READ: begin
                    staging[idx] <= rom_bits;
                    if (!last) idx <= idx + 1'b1;
                end
                DONE:    busy <= 1'b0;
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_sprite
        sprite_line_renderer u_renderer (
            .clk       (clk),
            .reset     (reset),
            .hpos      (hpos),
            .sprite_x  (sprite_x[9*i +: 9]),
            .sprite_en (sprite_en[i]),
            .commit    (commit),
            .row       (staging[i]),
            .hit       (hit_mask[i])
        );
    end

    assign gfx = display_on & (|hit_mask);

endmodule

// File: tb/tb_sprite_scanline_scheduler.sv
// Directed bench for sprite_scanline_scheduler: a table of single-sprite pixel
// vectors plus hand-written sequences for fetch timing, overlap and reset.
module tb_sprite_scanline_scheduler;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [8:0]     hpos, vpos;
    logic           display_on;
    logic [9*N-1:0] sprite_x, sprite_y;
    logic [N-1:0]   sprite_en;
    logic [3:0]     rom_yofs;
    logic [7:0]     rom_bits;
    logic [N-1:0]   hit_mask;
    logic           gfx, busy;

    int  rom_mode    = 0;
    bit  force_blank = 1'b0;
    int  n_checks    = 0;
    int  n_pass      = 0;

    always #5 clk = ~clk;

    // Mode 0: row r = 8'h0C | r.  Mode 1: every row = 8'b0000_0001.
    assign rom_bits = (rom_mode == 0) ? (8'h0C | {4'h0, rom_yofs}) : 8'h01;

    sprite_scanline_scheduler #(.NUM_SPRITES(N), .FETCH_HPOS(256), .V_TOTAL(262)) dut (
        .clk        (clk),
        .reset      (reset),
        .hpos       (hpos),
        .vpos       (vpos),
        .display_on (display_on),
        .sprite_x   (sprite_x),
        .sprite_y   (sprite_y),
        .sprite_en  (sprite_en),
        .rom_yofs   (rom_yofs),
        .rom_bits   (rom_bits),
        .hit_mask   (hit_mask),
        .gfx        (gfx),
        .busy       (busy)
    );

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Drive one pixel after the rising edge; return at the falling edge for sampling.
    task automatic tick(input int h, input int v);
        @(posedge clk);
        #1;
        hpos       = 9'(h);
        vpos       = 9'(v);
        display_on = (h < 256) && (v < 240) && !force_blank;
        @(negedge clk);
    endtask

    task automatic run(input int v, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) tick(h, v);
    endtask

    task automatic single_sprite(input int x, input int y, input int mode);
        sprite_x        = '0;
        sprite_y        = '0;
        sprite_en       = '0;
        sprite_x[8:0]   = 9'(x);
        sprite_y[8:0]   = 9'(y);
        sprite_en[0]    = 1'b1;
        rom_mode        = mode;
    endtask

    typedef struct {
        string name;
        int    x;
        int    y;
        int    mode;
        int    line;
        int    hpos;
        logic  exp_hit;
        logic  exp_gfx;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int busy_cycles;
        int prev;

        reset      = 1'b1;
        hpos       = '0;
        vpos       = '0;
        display_on = 1'b0;
        sprite_x   = '0;
        sprite_y   = '0;
        sprite_en  = '0;

        // Expected hit: column c = hpos-x-1, bit index c<8 ? c : 15-c of the fetched row.
        vecs.push_back('{"x260_hidden",   260, 128, 1, 128, 261, 1'b1, 1'b0});
        vecs.push_back('{"t1_row15_c0",   128, 128, 0, 128, 129, 1'b1, 1'b1});
        vecs.push_back('{"t1_row15_c4",   128, 128, 0, 128, 133, 1'b0, 1'b0});
        vecs.push_back('{"t1_row15_c12",  128, 128, 0, 128, 141, 1'b1, 1'b1});
        vecs.push_back('{"t1_row0_c0",    128, 128, 0, 143, 129, 1'b0, 1'b0});
        vecs.push_back('{"t1_row0_c2",    128, 128, 0, 143, 131, 1'b1, 1'b1});
        vecs.push_back('{"t1_line127",    128, 128, 0, 127, 131, 1'b0, 1'b0});
        vecs.push_back('{"t1_line144",    128, 128, 0, 144, 131, 1'b0, 1'b0});
        vecs.push_back('{"t2_h128",       128, 128, 1, 130, 128, 1'b0, 1'b0});
        vecs.push_back('{"t2_h129",       128, 128, 1, 130, 129, 1'b1, 1'b1});
        vecs.push_back('{"t2_h130",       128, 128, 1, 130, 130, 1'b0, 1'b0});
        vecs.push_back('{"t2_h144",       128, 128, 1, 130, 144, 1'b1, 1'b1});
        vecs.push_back('{"t2_h145",       128, 128, 1, 130, 145, 1'b0, 1'b0});
        vecs.push_back('{"t4_line0_c0",   128, 510, 0,   0, 129, 1'b1, 1'b1});
        vecs.push_back('{"t4_line0_c1",   128, 510, 0,   0, 130, 1'b0, 1'b0});
        vecs.push_back('{"t4_line0_c2",   128, 510, 0,   0, 131, 1'b1, 1'b1});
        vecs.push_back('{"t4_line1_c0",   128, 510, 0,   1, 129, 1'b0, 1'b0});
        vecs.push_back('{"t4_line13_c2",  128, 510, 0,  13, 131, 1'b1, 1'b1});
        vecs.push_back('{"t4_line14",     128, 510, 0,  14, 131, 1'b0, 1'b0});

        // Reset state
        run(0, 0, 2);
        check("rst_rom_yofs", int'(rom_yofs), 0);
        check("rst_hit_mask", int'(hit_mask), 0);
        check("rst_gfx",      int'(gfx),      0);
        check("rst_busy",     int'(busy),     0);
        reset = 1'b0;

        // Table: fetch in the blank of the preceding line, then draw up to the sample pixel
        foreach (vecs[k]) begin
            single_sprite(vecs[k].x, vecs[k].y, vecs[k].mode);
            prev = (vecs[k].line == 0) ? 261 : vecs[k].line - 1;
            run(prev, 250, 308);
            run(vecs[k].line, 0, vecs[k].hpos);
            check({vecs[k].name, "_hit"}, int'(hit_mask[0]), int'(vecs[k].exp_hit));
            check({vecs[k].name, "_gfx"}, int'(gfx),         int'(vecs[k].exp_gfx));
        end

        // Four sprites on one line: busy from the edge after hpos 256 through DONE
        sprite_x  = {9'd100, 9'd70, 9'd40, 9'd10};
        sprite_y  = {9'd50, 9'd50, 9'd50, 9'd50};
        sprite_en = 4'hF;
        rom_mode  = 0;
        busy_cycles = 0;
        for (int h = 250; h <= 308; h++) begin
            tick(h, 49);
            if (busy) busy_cycles++;
            if (h == 257) check("t3_busy_rise", int'(busy), 1);
            if (h == 258 || h == 260 || h == 262 || h == 264)
                check($sformatf("t3_rom_yofs_h%0d", h), int'(rom_yofs), 15);
        end
        check("t3_busy_cycles", busy_cycles, 2*N + 1);
        for (int h = 0; h <= 101; h++) begin
            tick(h, 50);
            if (h == 11)  check("t3_hit_s0", int'(hit_mask), 1);
            if (h == 41)  check("t3_hit_s1", int'(hit_mask), 2);
            if (h == 71)  check("t3_hit_s2", int'(hit_mask), 4);
            if (h == 101) check("t3_hit_s3", int'(hit_mask), 8);
        end

        // All sprites disabled: SETUP per sprite then DONE, nothing staged
        sprite_en   = '0;
        sprite_y    = '0;
        sprite_y[8:0] = 9'd510;
        sprite_x    = '0;
        sprite_x[8:0] = 9'd128;
        busy_cycles = 0;
        for (int h = 250; h <= 308; h++) begin
            tick(h, 261);
            if (busy) busy_cycles++;
        end
        check("t4_disabled_busy", busy_cycles, N + 1);
        sprite_en[0] = 1'b1;
        run(0, 0, 129);
        check("t4_disabled_blank", int'(hit_mask), 0);

        // sprite_en falling mid-sprite: the line finishes, the next fetch stages zero
        single_sprite(128, 128, 0);
        run(127, 250, 308);
        for (int h = 0; h <= 141; h++) begin
            if (h == 135) sprite_en[0] = 1'b0;
            tick(h, 128);
        end
        check("en_fall_finishes", int'(hit_mask[0]), 1);
        run(128, 142, 308);
        sprite_en[0] = 1'b1;
        run(129, 0, 130);
        check("en_fall_next_blank", int'(hit_mask[0]), 0);

        // Overlap at x=60, then display_on low masks gfx only
        sprite_x  = {9'd0, 9'd0, 9'd60, 9'd60};
        sprite_y  = {9'd0, 9'd0, 9'd100, 9'd100};
        sprite_en = 4'b0011;
        rom_mode  = 0;
        run(99, 250, 308);
        run(100, 0, 61);
        check("t5_overlap_mask", int'(hit_mask), 3);
        check("t5_overlap_gfx",  int'(gfx),      1);
        force_blank = 1'b1;
        tick(62, 100);
        check("t5_blank_mask", int'(hit_mask), 3);
        check("t5_blank_gfx",  int'(gfx),      0);
        force_blank = 1'b0;

        // Live sprite_x move mid-sprite restarts the column count
        single_sprite(128, 128, 1);
        run(127, 250, 308);
        run(128, 0, 132);
        sprite_x[8:0] = 9'd134;
        run(128, 133, 135);
        check("rehit_restart", int'(hit_mask[0]), 1);

        // Reset during READ of sprite 0
        single_sprite(128, 128, 0);
        run(127, 250, 258);
        check("t6_busy_pre", int'(busy), 1);
        reset = 1'b1;
        #1;
        check("t6_async_busy",     int'(busy),     0);
        check("t6_async_rom_yofs", int'(rom_yofs), 0);
        check("t6_async_hit",      int'(hit_mask), 0);
        check("t6_async_gfx",      int'(gfx),      0);
        run(127, 259, 260);
        reset = 1'b0;
        run(127, 261, 308);
        run(128, 0, 129);
        check("t6_line_blank", int'(hit_mask[0]), 0);
        run(128, 130, 308);
        run(129, 0, 130);
        check("t6_line_recovers", int'(hit_mask[0]), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
